// File: rtl/axi_pkg.sv
// Shared AXI4 types for the burst master: burst/response encodings, master FSM states
// and the 4 KB page-crossing check.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REJ,
        ST_AW,
        ST_WD,
        ST_BR,
        ST_AR,
        ST_RD,
        ST_DN
    } state_e;

    localparam int unsigned PAGE_BYTES = 4096;

    // True when a burst starting at page offset addr_lo runs past the end of its 4 KB page.
    function automatic logic crosses_4k(input logic [11:0] addr_lo,
                                        input logic [8:0]  beats,
                                        input int unsigned size_log2);
        int unsigned end_off;
        end_off = 32'(addr_lo) + (32'(beats) << size_log2);
        return end_off > PAGE_BYTES;
    endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 memory-mapped bus between the burst master and the interconnect.
interface axi_burst_master_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4
);
    logic [AXI_ADDR_WIDTH-1:0]   AWADDR;
    logic [AXI_ID_WIDTH-1:0]     AWID;
    logic [7:0]                  AWLEN;
    logic [2:0]                  AWSIZE;
    logic [1:0]                  AWBURST;
    logic                        AWVALID;
    logic                        AWREADY;

    logic [AXI_DATA_WIDTH-1:0]   WDATA;
    logic [AXI_DATA_WIDTH/8-1:0] WSTRB;
    logic                        WLAST;
    logic                        WVALID;
    logic                        WREADY;

    logic [1:0]                  BRESP;
    logic [AXI_ID_WIDTH-1:0]     BID;
    logic                        BVALID;
    logic                        BREADY;

    logic [AXI_ADDR_WIDTH-1:0]   ARADDR;
    logic [AXI_ID_WIDTH-1:0]     ARID;
    logic [7:0]                  ARLEN;
    logic [2:0]                  ARSIZE;
    logic [1:0]                  ARBURST;
    logic                        ARVALID;
    logic                        ARREADY;

    logic [AXI_DATA_WIDTH-1:0]   RDATA;
    logic [1:0]                  RRESP;
    logic [AXI_ID_WIDTH-1:0]     RID;
    logic                        RLAST;
    logic                        RVALID;
    logic                        RREADY;

    modport master (
        output AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BRESP, BID, BVALID, output BREADY,
        output ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input  RDATA, RRESP, RID, RLAST, RVALID, output RREADY
    );

    modport slave (
        input  AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BRESP, BID, BVALID, input BREADY,
        input  ARADDR, ARID, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RDATA, RRESP, RID, RLAST, RVALID, input RREADY
    );

endinterface

// File: rtl/axi_beat_counter.sv
// Remaining-beat counter for one burst: loaded with the beat count, decremented per
// data handshake; o_last flags the final beat.
module axi_beat_counter #(
    parameter int MAX_BEATS = 8,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_beats,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_beats;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_last = (r_count == CNT_W'(1));

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 master issuing one outstanding INCR burst (read or write) per request, with
// ID tagging/checking and a single done/done_err pulse per burst.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MAX_BEATS      = 8
) (
    input  logic                        M_AXI_ACLK,
    input  logic                        M_AXI_ARESETN,

    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_is_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]                  req_len,

    input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] wr_strb,
    input  logic                        wr_valid,
    output logic                        wr_ready,

    output logic [AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                        rd_last,
    output logic                        rd_valid,
    input  logic                        rd_ready,

    output logic                        done,
    output logic                        done_err,

    axi_burst_master_if.master          m_axi
);

    localparam int CNT_W     = $clog2(MAX_BEATS + 1);
    localparam int SIZE_LOG2 = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [2:0] AXI_SIZE = 3'(SIZE_LOG2);
    localparam logic [8:0] MAX_BEATS_9 = 9'(MAX_BEATS);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LSB_MASK = AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8 - 1);

    state_e                    r_state;
    logic                      r_req_ready;
    logic                      r_aw_valid;
    logic                      r_ar_valid;
    logic                      r_b_ready;
    logic                      r_done;
    logic                      r_done_err;
    logic                      r_err;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_ID_WIDTH-1:0]   r_issue_id;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [7:0]                r_len;

    logic [AXI_ADDR_WIDTH-1:0] w_addr_aligned;
    logic [8:0]                w_beats;
    logic                      w_accept;
    logic                      w_reject;
    logic                      w_in_wd;
    logic                      w_in_rd;
    logic                      w_w_hs;
    logic                      w_r_hs;
    logic                      w_last;
    logic                      w_load;
    logic [CNT_W-1:0]          w_load_beats;
    logic                      w_b_err;
    logic                      w_r_err;

    assign w_addr_aligned = req_addr & ~ADDR_LSB_MASK;
    assign w_beats        = 9'(req_len) + 9'd1;
    assign w_accept       = r_req_ready && req_valid;
    assign w_reject       = (w_beats > MAX_BEATS_9) ||
                            crosses_4k(w_addr_aligned[11:0], w_beats, SIZE_LOG2);
    assign w_load         = w_accept && !w_reject;
    assign w_load_beats   = CNT_W'(w_beats);

    assign w_in_wd = (r_state == ST_WD);
    assign w_in_rd = (r_state == ST_RD);
    assign w_w_hs  = w_in_wd && wr_valid && m_axi.WREADY;
    assign w_r_hs  = w_in_rd && m_axi.RVALID && rd_ready;

    assign w_b_err = (m_axi.BRESP != RESP_OKAY) || (m_axi.BID != r_issue_id);
    // RLAST must agree with our own beat count; the burst still ends on the counter.
    assign w_r_err = r_err || (m_axi.RRESP != RESP_OKAY) ||
                     (m_axi.RID != r_issue_id) || (m_axi.RLAST != w_last);

    axi_beat_counter #(
        .MAX_BEATS (MAX_BEATS),
        .CNT_W     (CNT_W)
    ) u_beat_cnt (
        .clk     (M_AXI_ACLK),
        .rst_n   (M_AXI_ARESETN),
        .i_load  (w_load),
        .i_beats (w_load_beats),
        .i_dec   (w_w_hs || w_r_hs),
        .o_last  (w_last)
    );

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_aw_valid  <= 1'b0;
            r_ar_valid  <= 1'b0;
            r_b_ready   <= 1'b0;
            r_done      <= 1'b0;
            r_done_err  <= 1'b0;
            r_err       <= 1'b0;
            r_id        <= '0;
            r_issue_id  <= '0;
            r_addr      <= '0;
            r_len       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_addr      <= w_addr_aligned;
                        r_len       <= req_len;
                        r_issue_id  <= r_id;
                        r_err       <= 1'b0;
                        if (w_reject) begin
                            r_state    <= ST_REJ;
                            r_done     <= 1'b1;
                            r_done_err <= 1'b1;
                        end else if (req_is_write) begin
                            r_state    <= ST_AW;
                            r_aw_valid <= 1'b1;
                        end else begin
                            r_state    <= ST_AR;
                            r_ar_valid <= 1'b1;
                        end
                    end
                end
                ST_REJ: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                ST_AW: begin
                    if (m_axi.AWREADY) begin
                        r_aw_valid <= 1'b0;
                        r_state    <= ST_WD;
                    end
                end
                ST_WD: begin
                    if (w_w_hs && w_last) begin
                        r_b_ready <= 1'b1;
                        r_state   <= ST_BR;
                    end
                end
                ST_BR: begin
                    if (m_axi.BVALID) begin
                        r_b_ready  <= 1'b0;
                        r_done     <= 1'b1;
                        r_done_err <= w_b_err;
                        r_state    <= ST_DN;
                    end
                end
                ST_AR: begin
                    if (m_axi.ARREADY) begin
                        r_ar_valid <= 1'b0;
                        r_state    <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (w_r_hs) begin
                        r_err <= w_r_err;
                        if (w_last) begin
                            r_done     <= 1'b1;
                            r_done_err <= w_r_err;
                            r_state    <= ST_DN;
                        end
                    end
                end
                ST_DN: begin
                    r_id        <= r_id + AXI_ID_WIDTH'(1);
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign done      = r_done;
    assign done_err  = r_done_err;

    assign m_axi.AWADDR  = r_addr;
    assign m_axi.AWID    = r_issue_id;
    assign m_axi.AWLEN   = r_len;
    assign m_axi.AWSIZE  = AXI_SIZE;
    assign m_axi.AWBURST = BURST_INCR;
    assign m_axi.AWVALID = r_aw_valid;

    // Data phases are pass-through, gated by state so nothing leaks before the address handshake.
    assign m_axi.WDATA  = wr_data;
    assign m_axi.WSTRB  = wr_strb;
    assign m_axi.WLAST  = w_in_wd && w_last;
    assign m_axi.WVALID = w_in_wd && wr_valid;
    assign wr_ready     = w_in_wd && m_axi.WREADY;

    assign m_axi.BREADY = r_b_ready;

    assign m_axi.ARADDR  = r_addr;
    assign m_axi.ARID    = r_issue_id;
    assign m_axi.ARLEN   = r_len;
    assign m_axi.ARSIZE  = AXI_SIZE;
    assign m_axi.ARBURST = BURST_INCR;
    assign m_axi.ARVALID = r_ar_valid;

    assign m_axi.RREADY = w_in_rd && rd_ready;
    assign rd_valid     = w_in_rd && m_axi.RVALID;
    assign rd_data      = m_axi.RDATA;
    assign rd_last      = w_in_rd && m_axi.RLAST;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: bursts, stalls, error responses, rejects,
// ID wrap and reset mid-burst, with a cycle-stepped AXI slave.
module tb_axi_burst_master;
    import axi_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 64;
    localparam int IW   = 4;
    localparam int MAXB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid;
    logic          req_ready;
    logic          req_is_write;
    logic [AW-1:0] req_addr;
    logic [7:0]    req_len;
    logic [DW-1:0] wr_data;
    logic [DW/8-1:0] wr_strb;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          rd_valid;
    logic          rd_ready;
    logic          done;
    logic          done_err;

    axi_burst_master_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) m_axi ();

    axi_burst_master #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .MAX_BEATS      (MAXB)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_write  (req_is_write),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .wr_data       (wr_data),
        .wr_strb       (wr_strb),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .rd_data       (rd_data),
        .rd_last       (rd_last),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .done          (done),
        .done_err      (done_err),
        .m_axi         (m_axi)
    );

    int           n_checks = 0;
    int           n_errors = 0;
    logic [IW-1:0] exp_id  = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int seed, input int beat);
        return 64'hC0DE_0000_0000_0000 | (64'(seed) << 16) | 64'(beat);
    endfunction

    task automatic clear_inputs();
        req_valid = 1'b0; req_is_write = 1'b0; req_addr = '0; req_len = '0;
        wr_data = '0; wr_strb = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        m_axi.AWREADY = 1'b0; m_axi.WREADY = 1'b0;
        m_axi.BRESP = '0; m_axi.BID = '0; m_axi.BVALID = 1'b0;
        m_axi.ARREADY = 1'b0;
        m_axi.RDATA = '0; m_axi.RRESP = '0; m_axi.RID = '0; m_axi.RLAST = 1'b0; m_axi.RVALID = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) next_cycle();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        exp_id = '0;
    endtask

    // Present a request once req_ready is seen; returns one cycle after acceptance.
    task automatic issue(input string tag, input bit is_wr, input logic [31:0] addr, input logic [7:0] len);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            next_cycle();
        end
        check({tag, "_req_ready"}, 64'(ok), 64'd1);
        req_is_write = is_wr;
        req_addr     = addr;
        req_len      = len;
        req_valid    = 1'b1;
        next_cycle();
        req_valid = 1'b0;
    endtask

    task automatic run_write(input string tag, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] bresp, input bit bad_bid, input bit exp_err);
        bit aw_hs     = 1'b0;
        bit b_hs      = 1'b0;
        bit w_early   = 1'b0;
        bit premature = 1'b0;
        int beats     = 0;
        issue(tag, 1'b1, addr, len);
        check({tag, "_awvalid"}, 64'(m_axi.AWVALID), 64'd1);
        check({tag, "_awaddr"},  64'(m_axi.AWADDR), 64'(addr & ~32'h7));
        check({tag, "_awlen"},   64'(m_axi.AWLEN), 64'(len));
        check({tag, "_awid"},    64'(m_axi.AWID), 64'(exp_id));
        check({tag, "_awsize"},  64'(m_axi.AWSIZE), 64'd3);
        check({tag, "_awburst"}, 64'(m_axi.AWBURST), 64'd1);
        for (int cyc = 0; cyc < 100 && !b_hs; cyc++) begin
            m_axi.AWREADY = 1'b1;
            m_axi.WREADY  = 1'b1;
            wr_valid      = (beats <= int'(len));
            wr_data       = pat(int'(exp_id), beats);
            wr_strb       = '1;
            m_axi.BVALID  = (beats > int'(len));
            m_axi.BRESP   = bresp;
            m_axi.BID     = bad_bid ? ~exp_id : exp_id;
            #1;
            if (done) premature = 1'b1;
            if (m_axi.WVALID && m_axi.WREADY) begin
                if (!aw_hs) w_early = 1'b1;
                check($sformatf("%s_wlast%0d", tag, beats), 64'(m_axi.WLAST), 64'(beats == int'(len)));
                beats++;
            end
            if (m_axi.AWVALID && m_axi.AWREADY) aw_hs = 1'b1;
            if (m_axi.BVALID && m_axi.BREADY) b_hs = 1'b1;
            next_cycle();
        end
        clear_inputs();
        check({tag, "_b_handshake"}, 64'(b_hs), 64'd1);
        check({tag, "_w_beats"},     64'(beats), 64'(int'(len) + 1));
        check({tag, "_w_before_aw"}, 64'(w_early), 64'd0);
        check({tag, "_done_early"},  64'(premature), 64'd0);
        check({tag, "_done"},        64'(done), 64'd1);
        check({tag, "_done_err"},    64'(done_err), 64'(exp_err));
        exp_id++;
        next_cycle();
        check({tag, "_done_pulse"},  64'(done), 64'd0);
    endtask

    task automatic run_read(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input int err_beat, input logic [1:0] rresp, input bit gaps,
                            input bit no_rlast, input bit exp_err);
        bit ar_hs     = 1'b0;
        bit premature = 1'b0;
        int beat      = 0;
        issue(tag, 1'b0, addr, len);
        check({tag, "_arvalid"}, 64'(m_axi.ARVALID), 64'd1);
        check({tag, "_awvalid"}, 64'(m_axi.AWVALID), 64'd0);
        check({tag, "_araddr"},  64'(m_axi.ARADDR), 64'(addr & ~32'h7));
        check({tag, "_arlen"},   64'(m_axi.ARLEN), 64'(len));
        check({tag, "_arid"},    64'(m_axi.ARID), 64'(exp_id));
        for (int cyc = 0; cyc < 200 && beat <= int'(len); cyc++) begin
            m_axi.ARREADY = 1'b1;
            m_axi.RVALID  = ar_hs && (!gaps || (cyc % 3) != 1);
            rd_ready      = !gaps || (cyc % 4) != 2;
            m_axi.RDATA   = pat(100 + int'(exp_id), beat);
            m_axi.RRESP   = (beat == err_beat) ? rresp : 2'b00;
            m_axi.RID     = exp_id;
            m_axi.RLAST   = !no_rlast && (beat == int'(len));
            #1;
            if (done) premature = 1'b1;
            if (rd_valid && rd_ready) begin
                check($sformatf("%s_rdata%0d", tag, beat), rd_data, pat(100 + int'(exp_id), beat));
                check($sformatf("%s_rlast%0d", tag, beat), 64'(rd_last),
                      64'(!no_rlast && beat == int'(len)));
                beat++;
            end
            if (m_axi.ARVALID && m_axi.ARREADY) ar_hs = 1'b1;
            next_cycle();
        end
        clear_inputs();
        check({tag, "_r_beats"},    64'(beat), 64'(int'(len) + 1));
        check({tag, "_done_early"}, 64'(premature), 64'd0);
        check({tag, "_done"},       64'(done), 64'd1);
        check({tag, "_done_err"},   64'(done_err), 64'(exp_err));
        exp_id++;
        next_cycle();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run_reject(input string tag, input bit is_wr, input logic [31:0] addr, input logic [7:0] len);
        issue(tag, is_wr, addr, len);
        check({tag, "_done"},     64'(done), 64'd1);
        check({tag, "_done_err"}, 64'(done_err), 64'd1);
        check({tag, "_awvalid"},  64'(m_axi.AWVALID), 64'd0);
        check({tag, "_arvalid"},  64'(m_axi.ARVALID), 64'd0);
        next_cycle();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_awvalid2"},   64'(m_axi.AWVALID), 64'd0);
        check({tag, "_arvalid2"},   64'(m_axi.ARVALID), 64'd0);
        check({tag, "_ready_again"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beats;
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) next_cycle();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_awvalid",   64'(m_axi.AWVALID), 64'd0);
        check("rst_arvalid",   64'(m_axi.ARVALID), 64'd0);
        check("rst_wvalid",    64'(m_axi.WVALID), 64'd0);
        check("rst_bready",    64'(m_axi.BREADY), 64'd0);
        check("rst_rready",    64'(m_axi.RREADY), 64'd0);
        check("rst_done",      64'(done), 64'd0);
        check("rst_done_err",  64'(done_err), 64'd0);
        check("rst_rd_valid",  64'(rd_valid), 64'd0);
        check("rst_wr_ready",  64'(wr_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        run_write("t1_wr8", 32'h0000_1000, 8'd7, 2'b00, 1'b0, 1'b0);
        run_read("t2_rd4_stall", 32'h0000_2004, 8'd3, -1, 2'b00, 1'b1, 1'b0, 1'b0);

        run_write("t3_slverr", 32'h0000_3000, 8'd3, 2'b10, 1'b0, 1'b1);
        run_read("t3_decerr", 32'h0000_3100, 8'd3, 1, 2'b11, 1'b0, 1'b0, 1'b1);
        run_read("t3_no_rlast", 32'h0000_3200, 8'd1, -1, 2'b00, 1'b0, 1'b1, 1'b1);
        run_read("t3_clean", 32'h0000_3300, 8'd0, -1, 2'b00, 1'b0, 1'b0, 1'b0);

        run_reject("t4_len_max", 1'b1, 32'h0000_4000, 8'd8);
        run_reject("t4_cross_wr", 1'b1, 32'h0000_0FF8, 8'd1);
        run_reject("t4_cross_rd", 1'b0, 32'h0000_0FF8, 8'd1);
        run_write("t4_page_edge", 32'h0000_0FC0, 8'd7, 2'b00, 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            if (i % 2 == 0)
                run_write($sformatf("t5_b%0d", i), 32'h0000_5000 + 32'(i) * 32'h100, 8'd1, 2'b00, 1'b0, 1'b0);
            else
                run_read($sformatf("t5_b%0d", i), 32'h0000_5000 + 32'(i) * 32'h100, 8'd1, -1, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        run_write("t5_bad_bid", 32'h0000_6000, 8'd0, 2'b00, 1'b1, 1'b1);

        issue("t6_req", 1'b1, 32'h0000_7000, 8'd7);
        beats = 0;
        for (int cyc = 0; cyc < 50 && beats < 2; cyc++) begin
            m_axi.AWREADY = 1'b1;
            m_axi.WREADY  = 1'b1;
            wr_valid      = 1'b1;
            wr_strb       = '1;
            #1;
            if (m_axi.WVALID && m_axi.WREADY) beats++;
            next_cycle();
        end
        check("t6_beat3_offered", 64'(m_axi.WVALID), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_wvalid",   64'(m_axi.WVALID), 64'd0);
        check("t6_rst_wr_ready", 64'(wr_ready), 64'd0);
        check("t6_rst_wlast",    64'(m_axi.WLAST), 64'd0);
        check("t6_rst_awvalid",  64'(m_axi.AWVALID), 64'd0);
        check("t6_rst_bready",   64'(m_axi.BREADY), 64'd0);
        check("t6_rst_req_rdy",  64'(req_ready), 64'd0);
        check("t6_rst_done",     64'(done), 64'd0);
        clear_inputs();
        repeat (2) next_cycle();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        exp_id = '0;
        check("t6_no_done_after_rst", 64'(done), 64'd0);
        run_write("t6_fresh", 32'h0000_7000, 8'd3, 2'b00, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
